// File: rtl/ossc_pkg.sv
// Shared types and constants for the OSSC output path.
// State encoding and source codes for video_src_switch.
package ossc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OLD,
    SWITCH,
    WAIT_NEW
  } vss_state_t;

  localparam logic SRC_VG = 1'b0;
  localparam logic SRC_SC = 1'b1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single quasi-static control bit.
// Asynchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/video_src_switch.sv
// Frame-aligned, blanked output-source changeover (scanconverter/videogen).
// Watchdog compiled in only with VIDEO_SRC_SWITCH_TIMEOUT_EN defined.
module video_src_switch
  import ossc_pkg::*;
#(
  parameter int BLANK_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 2700000,
  parameter int TMR_W          = 22
) (
  input  logic pclk,
  input  logic reset,
  input  logic sel_req,
  input  logic vs_sc,
  input  logic vs_vg,
  output logic sel,
  output logic blank,
  output logic busy,
  output logic timeout_flag
);

  localparam logic [3:0] BF = 4'(BLANK_FRAMES);

  logic       req_s;
  logic       vs_sc_q;
  logic       vs_vg_q;
  logic       edge_sc;
  logic       edge_vg;
  logic       edge_old;
  logic       edge_new;
  logic       frame_done;
  logic       tmr_zero;
  logic       target;
  logic [3:0] frame_cnt;
  vss_state_t state;

  sync_2ff u_req_sync (
    .clk (pclk),
    .rst (reset),
    .d   (sel_req),
    .q   (req_s)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vs_sc_q <= 1'b0;
      vs_vg_q <= 1'b0;
    end else begin
      vs_sc_q <= vs_sc;
      vs_vg_q <= vs_vg;
    end
  end

  assign edge_sc  = vs_sc & ~vs_sc_q;
  assign edge_vg  = vs_vg & ~vs_vg_q;
  assign edge_old = sel ? edge_sc : edge_vg;
  assign edge_new = target ? edge_sc : edge_vg;

  // An edge that completes the blanking beats a same-cycle expiry
  assign frame_done = edge_new && (sat_inc4(frame_cnt) >= BF);

`ifdef VIDEO_SRC_SWITCH_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] timer;
  logic             to_evt;

  assign tmr_zero = (timer == '0);

  assign to_evt = tmr_zero &&
    ((state == WAIT_OLD && req_s != sel && !edge_old) ||
     (state == WAIT_NEW && !frame_done));

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else begin
      case (state)
        IDLE:     if (req_s != sel) timer <= TMR_LOAD;
        SWITCH:   timer <= TMR_LOAD;
        default:  if (!tmr_zero) timer <= timer - TMR_W'(1);
      endcase
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      timeout_flag <= 1'b0;
    end else if (state == IDLE && req_s != sel) begin
      timeout_flag <= 1'b0;
    end else if (to_evt) begin
      timeout_flag <= 1'b1;
    end
  end
`else
  assign tmr_zero     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= SRC_VG;
      target    <= SRC_VG;
      blank     <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s != sel) begin
            state  <= WAIT_OLD;
            target <= req_s;
            busy   <= 1'b1;
          end
        end
        WAIT_OLD: begin
          if (req_s == sel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (edge_old || tmr_zero) begin
            state <= SWITCH;
            blank <= 1'b1;
          end
        end
        SWITCH: begin
          sel       <= target;
          frame_cnt <= 4'd0;
          if (BLANK_FRAMES == 0) begin
            state <= IDLE;
            blank <= 1'b0;
            busy  <= 1'b0;
          end else begin
            state <= WAIT_NEW;
          end
        end
        WAIT_NEW: begin
          if (edge_new) frame_cnt <= sat_inc4(frame_cnt);
          if (frame_done || tmr_zero) begin
            state <= IDLE;
            blank <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_src_switch.sv
// Bench for video_src_switch: three instances (default, short watchdog,
// zero blank frames) share random vsync traffic against an event model.
module tb_video_src_switch;

  localparam int MAXC = 4096;
  localparam int BIG  = 1 << 28;
  localparam int NONE = 1 << 30;

  logic pclk = 1'b0;
  logic reset = 1'b0;
  logic sel_req = 1'b0;
  logic vs_sc = 1'b0;
  logic vs_vg = 1'b0;
  logic [2:0] sel_o;
  logic [2:0] blank_o;
  logic [2:0] busy_o;
  logic [2:0] to_o;

  video_src_switch #(.BLANK_FRAMES(2)) u_d0 (
    .pclk(pclk), .reset(reset), .sel_req(sel_req),
    .vs_sc(vs_sc), .vs_vg(vs_vg), .sel(sel_o[0]),
    .blank(blank_o[0]), .busy(busy_o[0]), .timeout_flag(to_o[0])
  );

  video_src_switch #(
    .BLANK_FRAMES(2), .TIMEOUT_CYCLES(50), .TMR_W(22)
  ) u_d1 (
    .pclk(pclk), .reset(reset), .sel_req(sel_req),
    .vs_sc(vs_sc), .vs_vg(vs_vg), .sel(sel_o[1]),
    .blank(blank_o[1]), .busy(busy_o[1]), .timeout_flag(to_o[1])
  );

  video_src_switch #(.BLANK_FRAMES(0)) u_d2 (
    .pclk(pclk), .reset(reset), .sel_req(sel_req),
    .vs_sc(vs_sc), .vs_vg(vs_vg), .sel(sel_o[2]),
    .blank(blank_o[2]), .busy(busy_o[2]), .timeout_flag(to_o[2])
  );

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_fail = 0;

  bit vgv[MAXC];
  bit scv[MAXC];
  bit rqv[MAXC];
  logic [3:0] got_v[3][MAXC];

  bit cur_sel = 1'b0;
  bit flag_prev[3];
  bit fp_start[3];
  int kk[3];
  int mm[3];
  bit wo[3];
  bit wn[3];
  bit sc_old;
  bit sc_nw;
  bit sc_ab;
  int sc_n;

  function automatic int bf_of(input int d);
    return (d == 2) ? 0 : 2;
  endfunction

  function automatic int tmo_of(input int d);
`ifdef VIDEO_SRC_SWITCH_TIMEOUT_EN
    return (d == 1) ? 50 : 2700000;
`else
    return BIG;
`endif
  endfunction

  // cycle of the nth rising edge at or after 'from' (edge index = pclk edge)
  function automatic int nth_rise(input bit side, input int from,
                                  input int nth);
    int cnt;
    cnt = 0;
    for (int n = from; n < MAXC; n++) begin
      bit c;
      bit p;
      c = side ? scv[n] : vgv[n];
      p = side ? scv[n-1] : vgv[n-1];
      if (c && !p) begin
        cnt++;
        if (cnt == nth) return n;
      end
    end
    return NONE;
  endfunction

  function automatic logic [3:0] exp_vec(input int d, input int n);
    logic s, b, y, f;
    y = (n >= 3) && (n < mm[d]);
    b = !sc_ab && (n >= kk[d]) && (n < mm[d]);
    s = (!sc_ab && n >= kk[d] + 1) ? sc_nw : sc_old;
    if (n < 3) f = fp_start[d];
    else f = (wo[d] && n >= kk[d]) || (wn[d] && n >= mm[d]);
    return {s, b, y, f};
  endfunction

  task automatic gen_vs(input bit side, input int f, input int per,
                        input int w);
    for (int n = 0; n < MAXC; n++) begin
      bit v;
      v = (n >= f) && (((n - f) % per) < w);
      if (side) scv[n] = v;
      else vgv[n] = v;
    end
  endtask

  task automatic gen_rand(input bit side);
    int per;
    per = $urandom_range(250, 40);
    gen_vs(side, $urandom_range(per + 1, 2), per, $urandom_range(8, 1));
  endtask

  // Drives one changeover attempt, captures outputs, updates the model state
  task automatic run_change(input bit nw, input int ab_at, input bit rel,
                            input bit stop_mid);
    int t, bf, e, e2, lim, maxm, nn;
    logic [3:0] ev;
    sc_old = cur_sel;
    sc_nw = nw;
    sc_ab = (ab_at != 0);
    for (int n = 0; n < MAXC; n++)
      rqv[n] = (n >= 1 && (!sc_ab || n < ab_at)) ? nw : sc_old;
    maxm = 0;
    for (int d = 0; d < 3; d++) begin
      fp_start[d] = flag_prev[d];
      t = tmo_of(d);
      bf = bf_of(d);
      wo[d] = 1'b0;
      wn[d] = 1'b0;
      if (sc_ab) begin
        kk[d] = NONE;
        mm[d] = ab_at + 2;
      end else begin
        e = nth_rise(sc_old, 4, 1);
        if (e > 4 + t) begin
          kk[d] = 4 + t;
          wo[d] = 1'b1;
        end else kk[d] = e;
        if (bf == 0) mm[d] = kk[d] + 1;
        else begin
          e2 = nth_rise(nw, kk[d] + 2, bf);
          lim = kk[d] + 2 + t;
          if (e2 > lim) begin
            mm[d] = lim;
            wn[d] = 1'b1;
          end else mm[d] = e2;
        end
      end
      if (mm[d] > maxm) maxm = mm[d];
    end
    nn = (maxm + 3 > MAXC - 1) ? MAXC - 1 : maxm + 3;
    if (stop_mid) nn = kk[0] + 3;
    sc_n = nn;
    if (rel) reset = 1'b0;
    for (int n = 1; n <= nn; n++) begin
      sel_req = rqv[n];
      vs_vg = vgv[n];
      vs_sc = scv[n];
      @(posedge pclk);
      #1;
      for (int d = 0; d < 3; d++)
        got_v[d][n] = {sel_o[d], blank_o[d], busy_o[d], to_o[d]};
    end
    if (!stop_mid) begin
      for (int d = 0; d < 3; d++) begin
        ev = exp_vec(d, nn);
        flag_prev[d] = ev[0];
      end
      if (!sc_ab) cur_sel = nw;
      vs_vg = 1'b0;
      vs_sc = 1'b0;
      repeat (2) begin
        @(posedge pclk);
        #1;
      end
    end
  endtask

  task automatic test_reset;
    logic [11:0] got;
    sel_req = 1'b1;
    #2 reset = 1'b1;
    #1;
    got = {sel_o, blank_o, busy_o, to_o};
    n_chk++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: outputs got %h want 000", got);
    end
    repeat (3) begin
      @(posedge pclk);
      #1;
    end
    got = {sel_o, blank_o, busy_o, to_o};
    n_chk++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_hold: outputs got %h want 000", got);
    end
    cur_sel = 1'b0;
    for (int d = 0; d < 3; d++) flag_prev[d] = 1'b0;
  endtask

  task automatic test_release_switch;
    gen_vs(1'b0, 1000, 1000, 4);
    gen_vs(1'b1, 600, 1200, 6);
    run_change(1'b1, 0, 1'b1, 1'b0);
    for (int n = 1; n <= sc_n; n++)
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (got_v[d][n] !== exp_vec(d, n)) begin
          n_fail++;
          $display("FAIL release d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                   d, n, got_v[d][n], exp_vec(d, n));
        end
      end
  endtask

  task automatic test_abort;
    gen_vs(cur_sel, MAXC, 1, 0);
    gen_rand(!cur_sel);
    run_change(!cur_sel, $urandom_range(40, 2), 1'b0, 1'b0);
    for (int n = 1; n <= sc_n; n++)
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (got_v[d][n] !== exp_vec(d, n)) begin
          n_fail++;
          $display("FAIL abort d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                   d, n, got_v[d][n], exp_vec(d, n));
        end
      end
  endtask

  task automatic test_random;
    repeat (6) begin
      gen_rand(1'b0);
      gen_rand(1'b1);
      run_change(!cur_sel, 0, 1'b0, 1'b0);
      for (int n = 1; n <= sc_n; n++)
        for (int d = 0; d < 3; d++) begin
          n_chk++;
          if (got_v[d][n] !== exp_vec(d, n)) begin
            n_fail++;
            $display("FAIL random d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                     d, n, got_v[d][n], exp_vec(d, n));
          end
        end
    end
  endtask

  task automatic test_watchdog;
    gen_vs(cur_sel, 200, 150, 3);
    gen_rand(!cur_sel);
    run_change(!cur_sel, 0, 1'b0, 1'b0);
    for (int n = 1; n <= sc_n; n++)
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (got_v[d][n] !== exp_vec(d, n)) begin
          n_fail++;
          $display("FAIL watchdog d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                   d, n, got_v[d][n], exp_vec(d, n));
        end
      end
    gen_rand(1'b0);
    gen_rand(1'b1);
    run_change(!cur_sel, 0, 1'b0, 1'b0);
    for (int n = 1; n <= sc_n; n++)
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (got_v[d][n] !== exp_vec(d, n)) begin
          n_fail++;
          $display("FAIL flag_clear d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                   d, n, got_v[d][n], exp_vec(d, n));
        end
      end
  endtask

  task automatic test_same_cycle;
    gen_vs(cur_sel, 54, 200, 2);
    gen_rand(!cur_sel);
    run_change(!cur_sel, 0, 1'b0, 1'b0);
    for (int n = 1; n <= sc_n; n++)
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (got_v[d][n] !== exp_vec(d, n)) begin
          n_fail++;
          $display("FAIL same_cycle d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                   d, n, got_v[d][n], exp_vec(d, n));
        end
      end
  endtask

  task automatic test_reset_mid;
    logic [11:0] got;
    if (cur_sel) begin
      gen_rand(1'b0);
      gen_rand(1'b1);
      run_change(1'b0, 0, 1'b0, 1'b0);
      for (int n = 1; n <= sc_n; n++)
        for (int d = 0; d < 3; d++) begin
          n_chk++;
          if (got_v[d][n] !== exp_vec(d, n)) begin
            n_fail++;
            $display("FAIL to_vg d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                     d, n, got_v[d][n], exp_vec(d, n));
          end
        end
    end
    gen_rand(1'b0);
    gen_rand(1'b1);
    run_change(1'b1, 0, 1'b0, 1'b1);
    for (int n = 1; n <= sc_n; n++) begin
      n_chk++;
      if (got_v[0][n] !== exp_vec(0, n)) begin
        n_fail++;
        $display("FAIL pre_reset d0 cyc %0d: sel/blank/busy/to got %b want %b",
                 n, got_v[0][n], exp_vec(0, n));
      end
    end
    #1 reset = 1'b1;
    #1;
    got = {sel_o, blank_o, busy_o, to_o};
    n_chk++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid: outputs got %h want 000", got);
    end
    vs_vg = 1'b0;
    vs_sc = 1'b0;
    repeat (3) begin
      @(posedge pclk);
      #1;
    end
    cur_sel = 1'b0;
    for (int d = 0; d < 3; d++) flag_prev[d] = 1'b0;
    gen_rand(1'b0);
    gen_rand(1'b1);
    run_change(1'b1, 0, 1'b1, 1'b0);
    for (int n = 1; n <= sc_n; n++)
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (got_v[d][n] !== exp_vec(d, n)) begin
          n_fail++;
          $display("FAIL restart d%0d cyc %0d: sel/blank/busy/to got %b want %b",
                   d, n, got_v[d][n], exp_vec(d, n));
        end
      end
  endtask

  initial begin
    test_reset;
    test_release_switch;
    test_abort;
    test_random;
    test_watchdog;
    test_same_cycle;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
